hazard_sb_ctrl: RTL and testbench

// - Scoreboard-driven hazard/stall controller for the 5-stage pipeline (IF/ID/EX/MEM/WB); generalises the fixed-compare hazard unit.
// - Tracks per-register result-ready countdowns and a memory-wait FSM.
// - Emits per-latch stall/flush, PC enable and a hazard_t cause code.
// - Branches/jumps resolve in EX.

---
 rtl/hazard_sb_ctrl_pkg.sv | 30 +++
 rtl/hazard_sb_ctrl_scoreboard.sv | 43 ++++
 rtl/hazard_sb_ctrl.sv | 149 ++++++++++++++
 tb/tb_hazard_sb_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_sb_ctrl_pkg.sv
// Shared types for the scoreboard hazard controller: cause codes, FSM states and a
// scoreboard counter-width helper.
package hazard_sb_ctrl_pkg;

    localparam int unsigned REGW_DEF = 5;

    typedef logic [REGW_DEF-1:0] regbits_t;

    typedef enum logic [2:0] {
        HZ_NONE,
        HZ_DATA,
        HZ_CTRL,
        HZ_MEM,
        HZ_HALT
    } hazard_t;

    typedef enum logic [1:0] {
        RUN,
        MEMWAIT,
        HALTED
    } hzstate_t;

    function automatic int unsigned cnt_width(input int unsigned wb_dist,
                                              input int unsigned load_lat);
        int unsigned max_lat;
        max_lat = (wb_dist > load_lat + 1) ? wb_dist : load_lat + 1;
        return $clog2(max_lat + 1);
    endfunction

endpackage

// File: rtl/hazard_sb_ctrl_scoreboard.sv
// Per-register result-ready countdowns with one issue write port and two busy lookups.
// A source is busy while its countdown exceeds SLACK.
module hazard_sb_ctrl_scoreboard #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned REGW  = 5,
    parameter int unsigned CW    = 2,
    parameter int unsigned SLACK = 0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_freeze,
    input  logic            i_issue,
    input  logic [REGW-1:0] i_wsel,
    input  logic [CW-1:0]   i_lat,
    input  logic [REGW-1:0] i_rs,
    input  logic [REGW-1:0] i_rt,
    output logic            o_rs_busy,
    output logic            o_rt_busy
);

    logic [CW-1:0] r_cnt [NREGS];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                r_cnt[i] <= '0;
            end
        end else if (!i_freeze) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                // Register 0 is never written, so it can never report busy.
                if (i_issue && (i_wsel == REGW'(i)) && (i != 0)) begin
                    r_cnt[i] <= i_lat;
                end else if (r_cnt[i] != '0) begin
                    r_cnt[i] <= r_cnt[i] - CW'(1);
                end
            end
        end
    end

    assign o_rs_busy = r_cnt[i_rs] > CW'(SLACK);
    assign o_rt_busy = r_cnt[i_rt] > CW'(SLACK);

endmodule

// File: rtl/hazard_sb_ctrl.sv
// Scoreboard-driven stall/flush controller for the 5-stage pipeline with memory-wait FSM.
// Define HAZARD_FWD_EN for the forwarding build (only loads occupy the scoreboard).
module hazard_sb_ctrl
    import hazard_sb_ctrl_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned REGW     = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned WB_DIST  = 3,
    parameter int unsigned CNTW     = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_id_valid,
    input  logic [REGW-1:0] i_id_rs,
    input  logic [REGW-1:0] i_id_rt,
    input  logic            i_id_use_rs,
    input  logic            i_id_use_rt,
    input  logic [REGW-1:0] i_id_wsel,
    input  logic            i_id_regwrite,
    input  logic            i_id_is_load,
    input  logic            i_ex_redirect,
    input  logic            i_mem_req,
    input  logic            i_dhit,
    input  logic            i_ihit,
    input  logic            i_halt,
    output logic            o_pc_en,
    output logic            o_ifid_stall,
    output logic            o_idex_stall,
    output logic            o_exmem_stall,
    output logic            o_memwb_stall,
    output logic            o_ifid_flush,
    output logic            o_idex_flush,
    output hazard_t         o_hazard,
    output logic [CNTW-1:0] o_stall_cycles
);

    localparam int unsigned CW = cnt_width(WB_DIST, LOAD_LAT);

    logic [CW-1:0] w_lat;

`ifdef HAZARD_FWD_EN
    // Consumer reaches EX one cycle after ID, where forwarded data lands.
    localparam int unsigned SLACK = 1;
    assign w_lat = i_id_is_load ? CW'(LOAD_LAT + 1) : '0;
`else
    localparam int unsigned SLACK = 0;
    logic w_unused_load;
    assign w_unused_load = i_id_is_load;
    assign w_lat         = CW'(WB_DIST);
`endif

    hzstate_t        r_state;
    logic [CNTW-1:0] r_stall_cycles;
    logic            w_halt;
    logic            w_freeze;
    logic            w_data;
    logic            w_issue;
    logic            w_rs_busy;
    logic            w_rt_busy;
    logic            w_any;

    assign w_halt   = (r_state == HALTED) || i_halt;
    assign w_freeze = ((r_state == MEMWAIT) || i_mem_req) && !i_dhit;
    assign w_data   = i_id_valid && ((i_id_use_rs && w_rs_busy) || (i_id_use_rt && w_rt_busy));
    assign w_issue  = i_id_valid && !w_data && !i_ex_redirect && !w_freeze && !w_halt &&
                      i_id_regwrite && (i_id_wsel != '0);

    hazard_sb_ctrl_scoreboard #(
        .NREGS (NREGS),
        .REGW  (REGW),
        .CW    (CW),
        .SLACK (SLACK)
    ) u_scoreboard (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_freeze  (w_freeze || w_halt),
        .i_issue   (w_issue),
        .i_wsel    (i_id_wsel),
        .i_lat     (w_lat),
        .i_rs      (i_id_rs),
        .i_rt      (i_id_rt),
        .o_rs_busy (w_rs_busy),
        .o_rt_busy (w_rt_busy)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RUN;
        end else if (i_halt) begin
            r_state <= HALTED;
        end else begin
            case (r_state)
                RUN:     if (i_mem_req && !i_dhit) r_state <= MEMWAIT;
                MEMWAIT: if (i_dhit) r_state <= RUN;
                HALTED:  r_state <= HALTED;
                default: r_state <= RUN;
            endcase
        end
    end

    // Priority: HALT > MEM freeze > control redirect > data hazard > fetch bubble.
    always_comb begin
        o_pc_en       = 1'b0;
        o_ifid_stall  = 1'b0;
        o_idex_stall  = 1'b0;
        o_exmem_stall = 1'b0;
        o_memwb_stall = 1'b0;
        o_ifid_flush  = 1'b0;
        o_idex_flush  = 1'b0;
        o_hazard      = HZ_NONE;
        if (!i_rst_n) begin
            o_hazard = HZ_NONE;
        end else if (w_halt || w_freeze) begin
            o_ifid_stall  = 1'b1;
            o_idex_stall  = 1'b1;
            o_exmem_stall = 1'b1;
            o_memwb_stall = 1'b1;
            o_hazard      = w_halt ? HZ_HALT : HZ_MEM;
        end else if (i_ex_redirect) begin
            o_pc_en      = 1'b1;
            o_ifid_flush = 1'b1;
            o_idex_flush = 1'b1;
            o_hazard     = HZ_CTRL;
        end else if (w_data) begin
            o_ifid_stall = 1'b1;
            o_idex_flush = 1'b1;
            o_hazard     = HZ_DATA;
        end else if (!i_ihit) begin
            o_ifid_flush = 1'b1;
        end else begin
            o_pc_en = 1'b1;
        end
    end

    assign w_any = o_ifid_stall || o_idex_stall || o_exmem_stall || o_memwb_stall ||
                   o_ifid_flush || o_idex_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_any && !w_halt && (r_stall_cycles != {CNTW{1'b1}})) begin
            r_stall_cycles <= r_stall_cycles + CNTW'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_sb_ctrl.sv
// Directed bench for hazard_sb_ctrl: table of single-cycle vectors plus multi-cycle sequences.
// Expected stall counts follow HAZARD_FWD_EN when the build defines it.
module tb_hazard_sb_ctrl;
    import hazard_sb_ctrl_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam int N_ALU = 0;
    localparam int N_LD  = 1;
`else
    localparam int N_ALU = 3;
    localparam int N_LD  = 3;
`endif

    logic     clk = 1'b0;
    logic     rst_n;
    logic     valid, use_rs, use_rt, regwrite, is_load, redirect, mem_req, dhit, ihit, halt;
    regbits_t rs, rt, wsel;

    logic        pc_en, ifid_st, idex_st, exmem_st, memwb_st, ifid_fl, idex_fl;
    hazard_t     hz;
    logic [31:0] sc;
    logic        pc_en4, ifid_st4, idex_st4, exmem_st4, memwb_st4, ifid_fl4, idex_fl4;
    hazard_t     hz4;
    logic [3:0]  sc4;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_sc = 0;

    always #5 clk = ~clk;

    hazard_sb_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(valid), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_wsel(wsel),
        .i_id_regwrite(regwrite), .i_id_is_load(is_load), .i_ex_redirect(redirect),
        .i_mem_req(mem_req), .i_dhit(dhit), .i_ihit(ihit), .i_halt(halt),
        .o_pc_en(pc_en), .o_ifid_stall(ifid_st), .o_idex_stall(idex_st),
        .o_exmem_stall(exmem_st), .o_memwb_stall(memwb_st), .o_ifid_flush(ifid_fl),
        .o_idex_flush(idex_fl), .o_hazard(hz), .o_stall_cycles(sc)
    );

    hazard_sb_ctrl #(.CNTW(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_id_valid(valid), .i_id_rs(rs), .i_id_rt(rt),
        .i_id_use_rs(use_rs), .i_id_use_rt(use_rt), .i_id_wsel(wsel),
        .i_id_regwrite(regwrite), .i_id_is_load(is_load), .i_ex_redirect(redirect),
        .i_mem_req(mem_req), .i_dhit(dhit), .i_ihit(ihit), .i_halt(halt),
        .o_pc_en(pc_en4), .o_ifid_stall(ifid_st4), .o_idex_stall(idex_st4),
        .o_exmem_stall(exmem_st4), .o_memwb_stall(memwb_st4), .o_ifid_flush(ifid_fl4),
        .o_idex_flush(idex_fl4), .o_hazard(hz4), .o_stall_cycles(sc4)
    );

    logic [9:0] outs, outs4;
    assign outs  = {pc_en, ifid_st, idex_st, exmem_st, memwb_st, ifid_fl, idex_fl, hz};
    assign outs4 = {pc_en4, ifid_st4, idex_st4, exmem_st4, memwb_st4, ifid_fl4, idex_fl4, hz4};

    typedef struct {
        logic       valid, use_rs, use_rt;
        regbits_t   rs, rt;
        logic       redirect, mem_req, dhit, ihit;
        logic       pc;
        logic [3:0] st;
        logic [1:0] fl;
        hazard_t    hz;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic idle_in();
        valid = 0; use_rs = 0; use_rt = 0; rs = '0; rt = '0; wsel = '0;
        regwrite = 0; is_load = 0; redirect = 0; mem_req = 0; dhit = 0; ihit = 1; halt = 0;
    endtask

    // Check outputs mid-cycle, account the expected perf count, then advance one clock.
    task automatic cycle(input string nm, input logic pc, input logic [3:0] st,
                         input logic [1:0] fl, input hazard_t h);
        logic [9:0] e;
        #2;
        e = {pc, st, fl, h};
        check(nm, 32'(outs), 32'(e));
        check({nm, "_w4"}, 32'(outs4), 32'(e));
        if (((|st) || (|fl)) && (h != HZ_HALT)) exp_sc++;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_sc(input string nm);
        check(nm, sc, 32'(exp_sc));
        check({nm, "_sat4"}, 32'(sc4), (exp_sc > 15) ? 32'd15 : 32'(exp_sc));
    endtask

    task automatic chk_rst(input string nm);
        check(nm, 32'(outs), 32'd0);
        check({nm, "_w4"}, 32'(outs4), 32'd0);
        check({nm, "_sc"}, sc, 32'd0);
        check({nm, "_sc4"}, 32'(sc4), 32'd0);
    endtask

    initial begin
        //        v  rs rt  rs     rt     rdr mem dhit ihit pc st       fl     hz
        vt[0] = '{0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 4'b0000, 2'b00, HZ_NONE};
        vt[1] = '{0, 0, 0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 4'b0000, 2'b10, HZ_NONE};
        vt[2] = '{0, 0, 0, 5'd0, 5'd0, 1, 0, 0, 1, 1, 4'b0000, 2'b11, HZ_CTRL};
        vt[3] = '{0, 0, 0, 5'd0, 5'd0, 0, 1, 1, 1, 1, 4'b0000, 2'b00, HZ_NONE};
        vt[4] = '{1, 1, 1, 5'd7, 5'd9, 0, 0, 0, 1, 1, 4'b0000, 2'b00, HZ_NONE};
        vt[5] = '{0, 0, 0, 5'd0, 5'd0, 1, 0, 0, 0, 1, 4'b0000, 2'b11, HZ_CTRL};
        vt[6] = '{1, 0, 1, 5'd0, 5'd0, 0, 0, 0, 0, 0, 4'b0000, 2'b10, HZ_NONE};

        rst_n = 0;
        idle_in();
        #3;
        chk_rst("reset");
        @(posedge clk);
        #1;
        rst_n = 1;

        for (int i = 0; i < 7; i++) begin
            idle_in();
            valid = vt[i].valid; use_rs = vt[i].use_rs; use_rt = vt[i].use_rt;
            rs = vt[i].rs; rt = vt[i].rt; redirect = vt[i].redirect;
            mem_req = vt[i].mem_req; dhit = vt[i].dhit; ihit = vt[i].ihit;
            cycle($sformatf("vec%0d", i), vt[i].pc, vt[i].st, vt[i].fl, vt[i].hz);
        end
        chk_sc("sc_table");

        // ALU writer then dependent reader.
        idle_in(); valid = 1; regwrite = 1; wsel = 5'd5;
        cycle("alu_issue", 1, 4'b0000, 2'b00, HZ_NONE);
        idle_in(); valid = 1; use_rs = 1; rs = 5'd5;
        for (int k = 0; k < N_ALU; k++) cycle("alu_stall", 0, 4'b1000, 2'b01, HZ_DATA);
        cycle("alu_go", 1, 4'b0000, 2'b00, HZ_NONE);

        // Register 0 is never busy.
        idle_in(); valid = 1; regwrite = 1; wsel = 5'd0;
        cycle("r0_write", 1, 4'b0000, 2'b00, HZ_NONE);
        idle_in(); valid = 1; use_rs = 1; use_rt = 1;
        cycle("r0_read", 1, 4'b0000, 2'b00, HZ_NONE);

        // Reading its own destination sees the old (idle) count.
        idle_in(); valid = 1; regwrite = 1; wsel = 5'd6; use_rt = 1; rt = 5'd6;
        cycle("self_read", 1, 4'b0000, 2'b00, HZ_NONE);
        idle_in();
        for (int k = 0; k < 3; k++) cycle("drain0", 1, 4'b0000, 2'b00, HZ_NONE);

        // Load, then 4-cycle miss while the dependent waits: countdown must not move.
        idle_in(); valid = 1; regwrite = 1; is_load = 1; wsel = 5'd8;
        cycle("ld_issue", 1, 4'b0000, 2'b00, HZ_NONE);
        idle_in(); valid = 1; use_rs = 1; rs = 5'd8; mem_req = 1;
        for (int k = 0; k < 4; k++) cycle("miss", 0, 4'b1111, 2'b00, HZ_MEM);
        for (int k = 0; k < N_LD; k++) begin
            mem_req = (k == 0); dhit = (k == 0);
            cycle("ld_use", 0, 4'b1000, 2'b01, HZ_DATA);
        end
        mem_req = 0; dhit = 0;
        cycle("ld_go", 1, 4'b0000, 2'b00, HZ_NONE);
        chk_sc("sc_mid");

        // Redirect beats a pending data hazard.
        idle_in(); valid = 1; regwrite = 1; is_load = 1; wsel = 5'd9;
        cycle("ld9_issue", 1, 4'b0000, 2'b00, HZ_NONE);
        idle_in(); valid = 1; use_rs = 1; rs = 5'd9; redirect = 1;
        cycle("redir_data", 1, 4'b0000, 2'b11, HZ_CTRL);
        idle_in();
        for (int k = 0; k < 3; k++) cycle("drain1", 1, 4'b0000, 2'b00, HZ_NONE);

        // Redirect during a miss is deferred to the dhit cycle.
        idle_in(); redirect = 1; mem_req = 1;
        for (int k = 0; k < 2; k++) cycle("redir_miss", 0, 4'b1111, 2'b00, HZ_MEM);
        dhit = 1;
        cycle("redir_rel", 1, 4'b0000, 2'b11, HZ_CTRL);
        idle_in();
        cycle("after_rel", 1, 4'b0000, 2'b00, HZ_NONE);

        // Twenty fetch bubbles saturate the 4-bit counter.
        idle_in(); ihit = 0;
        for (int k = 0; k < 20; k++) cycle("fetch_bub", 0, 4'b0000, 2'b10, HZ_NONE);
        chk_sc("sc_sat");

        // Halt is sticky and does not count.
        idle_in(); halt = 1;
        cycle("halt", 0, 4'b1111, 2'b00, HZ_HALT);
        idle_in(); redirect = 1;
        for (int k = 0; k < 3; k++) cycle("halted", 0, 4'b1111, 2'b00, HZ_HALT);
        chk_sc("sc_halt");

        // Reset clears HALTED; then async reset in the middle of MEMWAIT.
        rst_n = 0; idle_in();
        #1;
        chk_rst("rst_halt");
        exp_sc = 0;
        @(posedge clk);
        #1;
        rst_n = 1; mem_req = 1;
        for (int k = 0; k < 2; k++) cycle("miss2", 0, 4'b1111, 2'b00, HZ_MEM);
        rst_n = 0;
        #1;
        chk_rst("rst_memwait");
        exp_sc = 0;
        @(posedge clk);
        #1;
        rst_n = 1; mem_req = 0; dhit = 0;
        cycle("post_rst", 1, 4'b0000, 2'b00, HZ_NONE);
        chk_sc("sc_end");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
